// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// dmem_responder (slave). The MEM stage keeps the request stable while stall=1.
interface dmem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_re;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_re, req_we, req_addr, req_wdata,
    input  stall, rvalid, rdata
  );

  modport slave (
    input  req_re, req_we, req_addr, req_wdata,
    output stall, rvalid, rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder.
// Accepts one read or write at a time, stalls the pipeline for 1+WAIT_CYCLES
// cycles, then completes the access against an internal word-addressed array.
// Optional feature macro: DMEM_RANGE_CHK_EN adds the err output and
// suppresses accesses whose upper address bits are nonzero. Without it the
// upper address bits are ignored and addresses alias modulo the array depth.
module dmem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hlt,
`ifdef DMEM_RANGE_CHK_EN
  output logic                err,
`endif
  dmem_responder_if.slave     bus
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [7:0] WAIT_L = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                stall_s;
  logic                access_s;
  logic                acc_we_s;
  logic [ADDR_W-1:0]   acc_addr_s;
  logic [DATA_W-1:0]   acc_wdata_s;
  logic [DEPTH_LOG2-1:0] acc_idx_s;
  logic                acc_oor_s;
  logic                mem_we_s;

  logic [DATA_W-1:0]   mem_q [0:DEPTH-1];

`ifdef DMEM_RANGE_CHK_EN
  logic                err_q, err_d;

  // True when any address bit above the array index is set.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] upper;
    upper = addr >> DEPTH_LOG2;
    return (upper != {ADDR_W{1'b0}});
  endfunction
`else
  // Upper address bits intentionally alias; sink them explicitly.
  logic unused_upper_s;
  assign unused_upper_s = ^acc_addr_s[ADDR_W-1:DEPTH_LOG2];
`endif

  // Next-state, request latching and stall generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    stall_s     = 1'b0;
    access_s    = 1'b0;
    acc_we_s    = we_q;
    acc_addr_s  = addr_q;
    acc_wdata_s = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if ((bus.req_re || bus.req_we) && !hlt) begin
          stall_s = 1'b1;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          we_d    = bus.req_we;
          cnt_d   = WAIT_L;
          if (WAIT_L == 8'd0) begin
            // No wait states: the access happens on the accept edge, so it
            // must use the live request rather than the not-yet-latched copy.
            state_d     = ST_DONE;
            access_s    = 1'b1;
            acc_we_s    = bus.req_we;
            acc_addr_s  = bus.req_addr;
            acc_wdata_s = bus.req_wdata;
          end else begin
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d  = ST_DONE;
          access_s = 1'b1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        // The request still presented here is the one just completed.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Access decode: array write enable, read data and range error.
  always_comb begin
    acc_idx_s = acc_addr_s[DEPTH_LOG2-1:0];
`ifdef DMEM_RANGE_CHK_EN
    acc_oor_s = addr_out_of_range(acc_addr_s);
    err_d     = access_s && acc_oor_s;
`else
    acc_oor_s = 1'b0;
`endif
    mem_we_s = access_s && acc_we_s && !acc_oor_s;
    rvalid_d = access_s && !acc_we_s;
    if (access_s && !acc_we_s) begin
      if (acc_oor_s) begin
        rdata_d = {DATA_W{1'b0}};
      end else begin
        rdata_d = mem_q[acc_idx_s];
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      we_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= {DATA_W{1'b0}};
`ifdef DMEM_RANGE_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
`ifdef DMEM_RANGE_CHK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Storage array; not cleared by reset, and a reset edge drops a pending write.
  always_ff @(posedge clk) begin
    if (rst && mem_we_s) begin
      mem_q[acc_idx_s] <= acc_wdata_s;
    end
  end

  assign bus.stall  = stall_s;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
`ifdef DMEM_RANGE_CHK_EN
  assign err        = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed cases plus randomized traffic,
// checked by a scoreboard fed from a word-level memory model.
module tb_dmem_responder;

  localparam int WAIT = 2;
  localparam int RUN  = 1 + WAIT;
`ifdef DMEM_RANGE_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    bit          is_read;
    logic [15:0] data;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic hlt;
  logic hlt0;
  logic err_m;
  logic err0;

  int checks = 0;
  int fails  = 0;
  int run_len = 0;
  exp_t exp_q[$];
  logic [15:0] mm [0:1023];
  logic [9:0]  pool [0:15];

  dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(WAIT)) u_dut (
    .clk(clk),
    .rst(rst),
    .hlt(hlt),
`ifdef DMEM_RANGE_CHK_EN
    .err(err_m),
`endif
    .bus(bus)
  );

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk),
    .rst(rst),
    .hlt(hlt0),
`ifdef DMEM_RANGE_CHK_EN
    .err(err0),
`endif
    .bus(bus0)
  );

`ifndef DMEM_RANGE_CHK_EN
  assign err_m = 1'b0;
  assign err0  = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word array indexed by address modulo 1024.
  function automatic exp_t model_op(input bit re, input bit we,
                                    input logic [15:0] addr, input logic [15:0] wd);
    exp_t e;
    int idx;
    bit oor;
    idx = int'(addr) % 1024;
    oor = CHK_EN && (int'(addr) >= 1024);
    e.is_read = !we;
    e.err = oor;
    e.data = 16'h0000;
    if (we) begin
      if (!oor) mm[idx] = wd;
    end else begin
      e.data = oor ? 16'h0000 : mm[idx];
    end
    if (!re && !we) e.is_read = 1'b0;
    return e;
  endfunction

  // Monitor: a stall run followed by a stall-free cycle marks a DONE cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      run_len = 0;
    end else if (bus.stall === 1'b1) begin
      run_len++;
      chk("rvalid_during_stall", {31'd0, bus.rvalid}, 32'd0);
    end else if (run_len > 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: completion with empty scoreboard, run %0d", run_len);
      end else begin
        e = exp_q.pop_front();
        chk("stall_len", run_len, RUN);
        chk("rvalid_done", {31'd0, bus.rvalid}, {31'd0, e.is_read});
        if (e.is_read) chk("rdata", {16'd0, bus.rdata}, {16'd0, e.data});
`ifdef DMEM_RANGE_CHK_EN
        chk("err_done", {31'd0, err_m}, {31'd0, e.err});
`endif
      end
      run_len = 0;
    end else begin
      chk("rvalid_idle", {31'd0, bus.rvalid}, 32'd0);
`ifdef DMEM_RANGE_CHK_EN
      chk("err_idle", {31'd0, err_m}, 32'd0);
`endif
    end
  end

  // Wait (bounded) until the main DUT drops stall after accepting.
  task automatic wait_done(input bit mid_hlt);
    int n = 0;
    @(negedge clk);
    while (bus.stall === 1'b1 && n < 300) begin
      n++;
      if (mid_hlt && n == 2) hlt = 1'b1;
      @(negedge clk);
    end
    if (n >= 300) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: stall still high after %0d cycles, expected low", n);
    end
  endtask

  // Issue one request on the main DUT; called just after a rising edge.
  task automatic issue(input bit re, input bit we, input logic [15:0] addr,
                       input logic [15:0] wd, input int hold, input bit mid_hlt);
    exp_t e;
    bus.req_re = re;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    if (hold > 0) begin
      hlt = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        chk("hlt_blocks_accept", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
      end
      hlt = 1'b0;
    end
    e = model_op(re, we, addr, wd);
    exp_q.push_back(e);
    wait_done(mid_hlt);
    @(posedge clk); #1;
    bus.req_re = 1'b0;
    bus.req_we = 1'b0;
    hlt = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] addr;
    logic [15:0] wd;
    int kind;
    int hold;
    bit mid;

    rst = 1'b0;
    hlt = 1'b0;
    hlt0 = 1'b0;
    bus.req_re = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = 16'h0000;
    bus.req_wdata = 16'h0000;
    bus0.req_re = 1'b0;
    bus0.req_we = 1'b0;
    bus0.req_addr = 16'h0000;
    bus0.req_wdata = 16'h0000;
    for (int i = 0; i < 1024; i++) mm[i] = 16'h0000;
    pool[0] = 10'h010;
    pool[1] = 10'h020;
    pool[2] = 10'h001;
    for (int i = 3; i < 16; i++) pool[i] = 10'((i * 61 + 5) % 1024);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state of both instances.
    @(negedge clk);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("rst_rdata", {16'd0, bus.rdata}, 32'd0);
    chk("rst0_stall", {31'd0, bus0.stall}, 32'd0);
    chk("rst0_rvalid", {31'd0, bus0.rvalid}, 32'd0);
    @(posedge clk); #1;

    // Case 1: write then read with two wait states.
    issue(1'b0, 1'b1, 16'h0010, 16'h1234, 0, 1'b0);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 1'b0);

    // Case 2: zero wait states on the second instance.
    bus0.req_we = 1'b1;
    bus0.req_addr = 16'h0010;
    bus0.req_wdata = 16'h1234;
    @(negedge clk);
    chk("w0_accept_stall", {31'd0, bus0.stall}, 32'd1);
    @(negedge clk);
    chk("w0_done_stall", {31'd0, bus0.stall}, 32'd0);
    chk("w0_done_rvalid", {31'd0, bus0.rvalid}, 32'd0);
    @(posedge clk); #1;
    bus0.req_we = 1'b0;
    bus0.req_re = 1'b1;
    @(negedge clk);
    chk("r0_accept_stall", {31'd0, bus0.stall}, 32'd1);
    chk("r0_accept_rvalid", {31'd0, bus0.rvalid}, 32'd0);
    @(negedge clk);
    chk("r0_done_stall", {31'd0, bus0.stall}, 32'd0);
    chk("r0_rvalid", {31'd0, bus0.rvalid}, 32'd1);
    chk("r0_rdata", {16'd0, bus0.rdata}, 32'h1234);
    @(posedge clk); #1;
    bus0.req_re = 1'b0;
    @(negedge clk);
    chk("r0_rvalid_pulse", {31'd0, bus0.rvalid}, 32'd0);
    @(posedge clk); #1;

    // Fill the address pool with known nonzero data.
    for (int i = 0; i < 16; i++) begin
      wd = 16'($urandom_range(1, 65535));
      issue(1'b0, 1'b1, {6'd0, pool[i]}, wd, 0, 1'b0);
    end

    // Case 3: reset in the second busy cycle abandons a write.
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 1'b0);
    bus.req_we = 1'b1;
    bus.req_addr = 16'h0020;
    bus.req_wdata = 16'hBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_stall", {31'd0, bus.stall}, 32'd0);
    chk("abort_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("abort_rdata", {16'd0, bus.rdata}, 32'd0);
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 16'h0020, 16'h0000, 0, 1'b0);

    // Case 4: halt holds off a read for five cycles.
    issue(1'b1, 1'b0, 16'h0001, 16'h0000, 5, 1'b0);

    // Case 5: out-of-range / aliasing write, then read of the aliased word.
    issue(1'b0, 1'b1, 16'h0410, 16'hAAAA, 0, 1'b0);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 1'b0);

    // Case 6: read and write together behave as a write.
    issue(1'b1, 1'b1, 16'h0001, 16'h5555, 0, 1'b0);
    issue(1'b1, 1'b0, 16'h0001, 16'h0000, 0, 1'b0);

    // Halt raised mid-access must not change the stall length.
    issue(1'b1, 1'b0, 16'h0020, 16'h0000, 0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      addr = {6'd0, pool[$urandom_range(0, 15)]};
      if ($urandom_range(0, 3) == 0) addr[15:10] = 6'($urandom_range(1, 63));
      wd = 16'($urandom);
      kind = $urandom_range(0, 9);
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      mid = ($urandom_range(0, 3) == 0);
      issue(kind < 4 || kind >= 8, kind >= 4, addr, wd, hold, mid);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
